// File: rtl/pwm_sequencer.sv
// pwm_sequencer
//   Plays a programmed table of PWM settings into a bank of pwm channels.
//   Each table step retargets one channel over the shared config bus. The
//   channel's update strobe pulses for one cycle, then the sequencer holds for
//   the step's programmed number of cycles before moving to the next step.
//
//   Optional feature macro: PWM_SEQ_LOOP_EN adds input i_loop. When i_loop is
//   high at the end of the last step, the sequence wraps to step 0 instead of
//   finishing.
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_start, i_stop                start (sampled in IDLE) / abort
//   i_num_steps                    steps to play (0..DEPTH), sampled at start
//   i_tbl_*                        table write port (one step per address)
//   i_loop                         repeat the sequence (PWM_SEQ_LOOP_EN only)
//   o_cfg_wave_length/pulse_width/active_high   shared channel config bus
//   o_cfg_update                   per-channel one-cycle update strobe
//   o_ch_enable                    per-channel enable
//   o_step_idx, o_busy, o_done     status
//
// States
//   IDLE  | waiting for start
//   FETCH | table read of the current step
//   APPLY | config bus driven, update strobe high for the target channel
//   GAP   | strobe low so the channel sees a fresh rising edge next time
//   HOLD  | counting the step's hold cycles
module pwm_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int WAVE_LEN_WIDTH = 11,
    parameter int DEPTH          = 16,
    parameter int HOLD_WIDTH     = 16,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic [AW:0]               i_num_steps,
    input  logic                      i_tbl_we,
    input  logic [AW-1:0]             i_tbl_addr,
    input  logic [CH_W-1:0]           i_tbl_ch,
    input  logic [WAVE_LEN_WIDTH-1:0] i_tbl_wave_length,
    input  logic [WAVE_LEN_WIDTH-1:0] i_tbl_pulse_width,
    input  logic                      i_tbl_active_high,
    input  logic                      i_tbl_enable,
    input  logic [HOLD_WIDTH-1:0]     i_tbl_hold,
`ifdef PWM_SEQ_LOOP_EN
    input  logic                      i_loop,
`endif
    output logic [WAVE_LEN_WIDTH-1:0] o_cfg_wave_length,
    output logic [WAVE_LEN_WIDTH-1:0] o_cfg_pulse_width,
    output logic                      o_cfg_active_high,
    output logic [NUM_CH-1:0]         o_cfg_update,
    output logic [NUM_CH-1:0]         o_ch_enable,
    output logic [AW-1:0]             o_step_idx,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int ENTRY_W = CH_W + 2 * WAVE_LEN_WIDTH + 2 + HOLD_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_GAP,
        S_HOLD
    } state_t;

    state_t                    r_state;
    logic [ENTRY_W-1:0]        r_tbl [DEPTH];
    logic [AW:0]               r_num;
    logic [HOLD_WIDTH-1:0]     r_hold_cnt;
    logic [WAVE_LEN_WIDTH-1:0] r_wave_length;
    logic [WAVE_LEN_WIDTH-1:0] r_pulse_width;
    logic                      r_active_high;
    logic [NUM_CH-1:0]         r_update;
    logic [NUM_CH-1:0]         r_enable;
    logic [AW-1:0]             r_step_idx;
    logic                      r_done;

    logic [ENTRY_W-1:0]        w_rd;
    logic [CH_W-1:0]           w_rd_ch;
    logic [WAVE_LEN_WIDTH-1:0] w_rd_wl;
    logic [WAVE_LEN_WIDTH-1:0] w_rd_pw;
    logic                      w_rd_ah;
    logic                      w_rd_en;
    logic [HOLD_WIDTH-1:0]     w_rd_hold;
    logic                      w_last;
    logic                      w_loop;
    logic [AW:0]               w_num_clamped;

`ifdef PWM_SEQ_LOOP_EN
    assign w_loop = i_loop;
`else
    assign w_loop = 1'b0;
`endif

    // Table storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_tbl_we) begin
            r_tbl[i_tbl_addr] <= {i_tbl_ch, i_tbl_wave_length, i_tbl_pulse_width,
                                  i_tbl_active_high, i_tbl_enable, i_tbl_hold};
        end
    end

    // The read is captured straight into the output registers on the FETCH
    // edge, so a same-cycle write to that address yields the old entry.
    assign w_rd = r_tbl[r_step_idx];
    assign {w_rd_ch, w_rd_wl, w_rd_pw, w_rd_ah, w_rd_en, w_rd_hold} = w_rd;

    assign w_last        = ({1'b0, r_step_idx} == (r_num - 1'b1));
    assign w_num_clamped = (i_num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_num_steps;

    // r_done is raised on entry to the final cycle of the last step. The
    // end-of-step decision then reuses it, so a change on i_loop cannot split
    // the done pulse from the return to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_num         <= '0;
            r_hold_cnt    <= '0;
            r_wave_length <= '0;
            r_pulse_width <= '0;
            r_active_high <= 1'b0;
            r_update      <= '0;
            r_enable      <= '0;
            r_step_idx    <= '0;
            r_done        <= 1'b0;
        end else begin
            r_update <= '0;
            r_done   <= 1'b0;
            if (i_stop && r_state != S_IDLE) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !i_stop) begin
                            if (i_num_steps == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_num      <= w_num_clamped;
                                r_step_idx <= '0;
                                r_state    <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        r_wave_length <= w_rd_wl;
                        r_pulse_width <= w_rd_pw;
                        r_active_high <= w_rd_ah;
                        r_hold_cnt    <= w_rd_hold;
                        // An out-of-range channel matches no index: no strobe, no enable change.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (w_rd_ch == i[CH_W-1:0]) begin
                                r_update[i] <= 1'b1;
                                r_enable[i] <= w_rd_en;
                            end
                        end
                        r_state <= S_APPLY;
                    end
                    S_APPLY: begin
                        r_state <= S_GAP;
                        if (r_hold_cnt == '0 && w_last && !w_loop) r_done <= 1'b1;
                    end
                    S_GAP, S_HOLD: begin
                        if (r_hold_cnt == '0) begin
                            if (r_done) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_step_idx <= w_last ? '0 : r_step_idx + 1'b1;
                                r_state    <= S_FETCH;
                            end
                        end else begin
                            r_state    <= S_HOLD;
                            r_hold_cnt <= r_hold_cnt - 1'b1;
                            if (r_hold_cnt == HOLD_WIDTH'(1) && w_last && !w_loop) r_done <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_cfg_wave_length = r_wave_length;
    assign o_cfg_pulse_width = r_pulse_width;
    assign o_cfg_active_high = r_active_high;
    assign o_cfg_update      = r_update;
    assign o_ch_enable       = r_enable;
    assign o_step_idx        = r_step_idx;
    assign o_busy            = (r_state != S_IDLE);
    assign o_done            = r_done;

endmodule
